// File: rtl/cordic_vector_pkg.sv
// Shared CORDIC constants: Q-format widths, FSM encodings,
// arctangent table, gain constant and output saturation.
package cordic_vector_pkg;

  localparam int IO_W = 16;
  localparam int DP_W = 18;
  localparam int PR_W = 34;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_CALC  = 2'd1;
  localparam logic [1:0] S_SCALE = 2'd2;

  localparam logic signed [15:0] SCALE_Q7 = 16'sh004D;
  localparam logic signed [17:0] HALF_PI_Q14 = 18'sh06488;

  typedef struct packed {
    logic signed [DP_W-1:0] x;
    logic signed [DP_W-1:0] y;
    logic signed [DP_W-1:0] z;
  } cv_vec_t;

  // atan(2^-i) in Q14
  function automatic logic [15:0] atan_q14(input logic [2:0] i);
    logic [15:0] a;
    case (i)
      3'd0:    a = 16'h3244;
      3'd1:    a = 16'h1DAC;
      3'd2:    a = 16'h0FAE;
      3'd3:    a = 16'h07F5;
      3'd4:    a = 16'h03FF;
      3'd5:    a = 16'h0200;
      3'd6:    a = 16'h0100;
      default: a = 16'h0080;
    endcase
    return a;
  endfunction

  function automatic logic [15:0] sat16(
    input logic signed [PR_W-1:0] v
  );
    logic [15:0] r;
    if (v > 34'sd32767)
      r = 16'h7FFF;
    else if (v < 34'sd0)
      r = 16'h0000;
    else
      r = v[15:0];
    return r;
  endfunction

endpackage

// File: rtl/cordic_vector_if.sv
// Request/result bundle between a client and the
// vectoring CORDIC engine.
interface cordic_vector_if;
  import cordic_vector_pkg::*;

  logic            start;
  logic [IO_W-1:0] x_i;
  logic [IO_W-1:0] y_i;
  logic [IO_W-1:0] mag_o;
  logic [IO_W-1:0] ang_o;
  logic            ready;
  logic            valid_o;

  modport master (
    output start, x_i, y_i,
    input  mag_o, ang_o, ready, valid_o
  );

  modport slave (
    input  start, x_i, y_i,
    output mag_o, ang_o, ready, valid_o
  );

endinterface

// File: rtl/cordic_vector_rom.sv
// Combinational arctangent ROM, read by iteration index.
// Words past DEPTH read as zero.
module cordic_vector_rom
  import cordic_vector_pkg::*;
#(
  parameter int DW    = 16,
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic          i_oe,
  input  logic [AW-1:0] i_addr,
  output logic [DW-1:0] o_data
);

  always_comb begin
    o_data = '0;
    if (i_oe && (int'(i_addr) < DEPTH))
      o_data = DW'(atan_q14(3'(i_addr)));
  end

endmodule

// File: rtl/cordic_vector.sv
// Iterative vectoring-mode CORDIC: (x,y) Q8.7 in,
// magnitude Q8.7 and atan2 angle Q3.13 out.
module cordic_vector
  import cordic_vector_pkg::*;
#(
  parameter int ITER = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  cordic_vector_if.slave   bus
);

  logic [1:0]             r_state;
  logic [2:0]             r_cnt;
  cv_vec_t                r_v;
  logic                   r_zero;
  logic [IO_W-1:0]        r_mag;
  logic [IO_W-1:0]        r_ang;
  logic                   r_ready;
  logic                   r_valid;

  logic [15:0]            w_atan;
  logic signed [DP_W-1:0] w_a;
  logic signed [DP_W-1:0] w_xi;
  logic signed [DP_W-1:0] w_yi;
  logic signed [DP_W-1:0] w_xs;
  logic signed [DP_W-1:0] w_ys;
  cv_vec_t                w_nxt;
  cv_vec_t                w_pre;
  logic signed [PR_W-1:0] w_p;

  cordic_vector_rom #(
    .DW    (16),
    .DEPTH (8),
    .AW    (3)
  ) u_rom (
    .i_oe   (1'b1),
    .i_addr (r_cnt[2:0]),
    .o_data (w_atan)
  );

  assign w_xi = {{2{bus.x_i[15]}}, bus.x_i};
  assign w_yi = {{2{bus.y_i[15]}}, bus.y_i};

  // Fold left half-plane into the right so CALC converges
  always_comb begin
    w_pre.x = w_xi;
    w_pre.y = w_yi;
    w_pre.z = '0;
    if (w_xi[DP_W-1] && !w_yi[DP_W-1]) begin
      w_pre.x = w_yi;
      w_pre.y = -w_xi;
      w_pre.z = HALF_PI_Q14;
    end else if (w_xi[DP_W-1]) begin
      w_pre.x = -w_yi;
      w_pre.y = w_xi;
      w_pre.z = -HALF_PI_Q14;
    end
  end

  always_comb begin
    w_a  = {2'b00, w_atan};
    w_xs = r_v.x >>> r_cnt;
    w_ys = r_v.y >>> r_cnt;
    if (!r_v.y[DP_W-1]) begin
      w_nxt.x = r_v.x + w_ys;
      w_nxt.y = r_v.y - w_xs;
      w_nxt.z = r_v.z + w_a;
    end else begin
      w_nxt.x = r_v.x - w_ys;
      w_nxt.y = r_v.y + w_xs;
      w_nxt.z = r_v.z - w_a;
    end
    w_p = 34'(r_v.x) * 34'(SCALE_Q7);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_v     <= '0;
      r_zero  <= 1'b0;
      r_mag   <= '0;
      r_ang   <= '0;
      r_ready <= 1'b1;
      r_valid <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_ready <= 1'b0;
            r_cnt   <= '0;
            r_v     <= w_pre;
            r_zero  <= (bus.x_i == '0) &&
                       (bus.y_i == '0);
            r_state <= S_CALC;
          end
        end
        S_CALC: begin
          r_v   <= w_nxt;
          r_cnt <= r_cnt + 3'd1;
          if (r_cnt == 3'(ITER - 1))
            r_state <= S_SCALE;
        end
        S_SCALE: begin
          if (r_zero) begin
            r_mag <= '0;
            r_ang <= '0;
          end else begin
            r_mag <= sat16(w_p >>> 7);
            r_ang <= r_v.z[16:1];
          end
          r_ready <= 1'b1;
          r_valid <= 1'b1;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
          r_ready <= 1'b1;
        end
      endcase
    end
  end

  assign bus.mag_o   = r_mag;
  assign bus.ang_o   = r_ang;
  assign bus.ready   = r_ready;
  assign bus.valid_o = r_valid;

endmodule
